sprite_mover: RTL and testbench
===============================

// Module: sprite_mover
// PURPOSE
//  Next-generation player-sprite engine for the VGA game layer.
//  - Clears the screen, draws a sprite from a 1-cycle-latency colour ROM, then moves it horizontally on left/right commands.
//  - Each move erases the old footprint, clamps the new position to the screen and redraws the sprite.
//  - Generalises the fixed 11x10 rocket: parametrised size, step, start position and transparent colour.
//  - Drives the shared VGA pixel-write port (xout/yout/colourOut/drawEn).
// PARAMETERS
//  X_SCREEN_PIXELS  160  screen width in pixels
//  Y_SCREEN_PIXELS  120  screen height in pixels
//  SPRITE_W         11   sprite width in pixels; legal range 1..X_SCREEN_PIXELS
//  SPRITE_H         10   sprite height in pixels; Y_START+SPRITE_H <= Y_SCREEN_PIXELS
//  X_START          73   sprite left x after reset and after each start
//  Y_START          105  sprite top y; fixed row
//  STEP             5    pixels moved per command
//  ADDR_W           7    ROM address width; 2**ADDR_W >= SPRITE_W*SPRITE_H
//  TRANSPARENT      3'b000  ROM colour that is skipped on draw (drawEn held low for that pixel)
// PORTS
//  clk        in   1       system clock
//  reset      in   1       synchronous, active-high reset
//  start      in   1       begin clear+draw; sampled only in S_IDLE
//  left       in   1       move-left request, level; sampled only in S_READY
//  right      in   1       move-right request, level; sampled only in S_READY
//  rom_data   in   3       sprite colour, valid 1 cycle after rom_addr
//  rom_addr   out  ADDR_W  sprite ROM address, row-major, index = row*SPRITE_W+col
//  xout       out  8       pixel x for the VGA write
//  yout       out  7       pixel y for the VGA write
//  colourOut  out  3       pixel colour for the VGA write
//  drawEn     out  1       pixel write strobe; xout/yout/colourOut valid when high
//  xpos       out  8       current sprite left x
//  ready      out  1       high in S_READY only
//  moveDone   out  1       1-cycle pulse when a move (or a no-op move) completes
// BEHAVIOUR
//  Reset: all outputs 0 except xpos=X_START. State S_IDLE. Reset mid-operation aborts any sweep immediately; nothing is resumed.
//  States and transitions:
//   - S_IDLE -> S_CLEAR on start.
//   - S_CLEAR -> S_DRAW after the last screen pixel.
//   - S_DRAW -> S_READY after the last sprite pixel.
//   - S_READY -> S_UPDATE when exactly one of left/right is high.
//   - S_UPDATE -> S_ERASE if the target x differs from xpos; otherwise -> S_READY with moveDone.
//   - S_ERASE -> S_REDRAW.
//   - S_REDRAW -> S_READY with moveDone.
//  Pipelining: every sweep has a 1-cycle pipeline. The coordinate counters drive rom_addr. xout/yout/drawEn are registered one cycle later, so they align with rom_data.
//  S_CLEAR: writes every pixel black. Order is x fastest, then y, from (0,0) to (159,119). drawEn is high for 19200 consecutive cycles.
//  S_ERASE: writes the old footprint black. Covers xpos..xpos+SPRITE_W-1 by Y_START..Y_START+SPRITE_H-1, using SPRITE_W*SPRITE_H write cycles.
//  S_DRAW and S_REDRAW: sweep the footprint at xpos, row-major, with rom_addr incrementing from 0.
//   - colourOut = rom_data.
//   - drawEn is low for pixels whose rom_data == TRANSPARENT.
//   - rom_addr returns to 0 at sweep end.
//  S_UPDATE (1 cycle): computes the target x; xpos takes the target.
//   - left: target = (xpos < STEP) ? 0 : xpos-STEP.
//   - right: target = min(xpos+STEP, X_SCREEN_PIXELS-SPRITE_W).
//   - Arithmetic is done 9 bits wide so a right move cannot wrap.
//   - Erase uses the pre-update xpos (latched as old_x).
//  Simultaneous commands:
//   - left and right both high in S_READY: ignored, stays in S_READY.
//   - Commands outside S_READY are ignored, not queued.
//   - A held command auto-repeats: one move per visit to S_READY.
//  ready deasserts the cycle after a command is accepted. drawEn is never high in S_IDLE, S_READY or S_UPDATE.
//  start outside S_IDLE is ignored. Returning to S_IDLE requires reset.
// TESTING
//  T1:
//   - Stimulus: reset, then start pulse.
//   - Required response: exactly 19200 black writes covering (0,0)..(159,119) once each.
//   - Then 110 sprite writes at x 73..83, y 105..114, minus transparent pixels; then ready=1, xpos=73.
//  T2:
//   - Stimulus: left for 1 cycle in S_READY.
//   - Required response: 110 black writes at x 73..83; then sprite writes at x 68..78; moveDone pulses once; xpos=68.
//  T3:
//   - Stimulus: left held until xpos stops changing.
//   - Required response: xpos sequence 68,63,...,3,0. At xpos=0 a further left gives moveDone with zero drawEn cycles.
//  T4:
//   - Stimulus: right held from xpos=73.
//   - Required response: xpos 78,...,148, then clamps at 149 (=160-11) and never writes x>159.
//  T5:
//   - Stimulus: left and right both high in S_READY for 10 cycles.
//   - Required response: no state change, no drawEn, ready stays 1.
//  T6:
//   - Stimulus: assert reset mid-S_ERASE, then ROM colour 3'b000 at address 0 during redraw.
//   - Required response: after reset, outputs 0, xpos=73, S_IDLE. On the next draw, pixel (73,105) gets no drawEn and rom_addr/colour stay aligned.

Source files
------------

// File: rtl/sprite_mover.sv
// Player-sprite engine: clears the screen, draws a sprite from a 1-cycle ROM and
// moves it horizontally, erasing and redrawing the footprint on each move.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start after reset
// S_CLEAR  | sweeping the whole screen black
// S_DRAW   | first sprite draw at xpos
// S_READY  | accepting a single left or right command
// S_UPDATE | computing the clamped target x and latching old_x
// S_ERASE  | sweeping the old footprint black
// S_REDRAW | drawing the sprite at the new xpos
module sprite_mover #(
    parameter int          X_SCREEN_PIXELS = 160,
    parameter int          Y_SCREEN_PIXELS = 120,
    parameter int          SPRITE_W        = 11,
    parameter int          SPRITE_H        = 10,
    parameter int          X_START         = 73,
    parameter int          Y_START         = 105,
    parameter int          STEP            = 5,
    parameter int          ADDR_W          = 7,
    parameter logic [2:0]  TRANSPARENT     = 3'b000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              left,
    input  logic              right,
    input  logic [2:0]        rom_data,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        xout,
    output logic [6:0]        yout,
    output logic [2:0]        colourOut,
    output logic              drawEn,
    output logic [7:0]        xpos,
    output logic              ready,
    output logic              moveDone
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DRAW,
        S_READY,
        S_UPDATE,
        S_ERASE,
        S_REDRAW
    } state_t;

    localparam logic [7:0] SCR_W_M1 = 8'(X_SCREEN_PIXELS - 1);
    localparam logic [6:0] SCR_H_M1 = 7'(Y_SCREEN_PIXELS - 1);
    localparam logic [7:0] SPR_W_M1 = 8'(SPRITE_W - 1);
    localparam logic [6:0] SPR_H_M1 = 7'(SPRITE_H - 1);
    localparam logic [8:0] X_MAX    = 9'(X_SCREEN_PIXELS - SPRITE_W);
    localparam logic [8:0] STEP9    = 9'(STEP);
    localparam logic [7:0] X_START8 = 8'(X_START);
    localparam logic [6:0] Y_START7 = 7'(Y_START);

    state_t            state;
    logic [7:0]        cx;
    logic [6:0]        cy;
    logic              flush;
    logic              dir_left;
    logic [7:0]        old_x;
    logic [7:0]        xpos_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ready_q;
    logic              move_done_q;

    logic              pv_q;
    logic              pdraw_q;
    logic [7:0]        px_q;
    logic [6:0]        py_q;

    logic [7:0]        sw_m1;
    logic [6:0]        sh_m1;
    logic [7:0]        base_x;
    logic [6:0]        base_y;
    logic              is_draw;
    logic              in_sweep;
    logic              last_pix;

    logic [8:0]        x9;
    logic [8:0]        sum9;
    logic [8:0]        left_t;
    logic [8:0]        right_t;
    logic [7:0]        target;

    always_comb begin
        sw_m1   = SPR_W_M1;
        sh_m1   = SPR_H_M1;
        base_x  = xpos_q;
        base_y  = Y_START7;
        is_draw = 1'b1;
        case (state)
            S_CLEAR: begin
                sw_m1   = SCR_W_M1;
                sh_m1   = SCR_H_M1;
                base_x  = 8'd0;
                base_y  = 7'd0;
                is_draw = 1'b0;
            end
            S_ERASE: begin
                base_x  = old_x;
                is_draw = 1'b0;
            end
            default: ;
        endcase
        in_sweep = (state == S_CLEAR) || (state == S_DRAW) ||
                   (state == S_ERASE) || (state == S_REDRAW);
        last_pix = (cx == sw_m1) && (cy == sh_m1);
    end

    // 9-bit arithmetic keeps a right step from wrapping past 255
    always_comb begin
        x9      = {1'b0, xpos_q};
        sum9    = x9 + STEP9;
        left_t  = (x9 < STEP9) ? 9'd0 : (x9 - STEP9);
        right_t = (sum9 > X_MAX) ? X_MAX : sum9;
        target  = dir_left ? left_t[7:0] : right_t[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            cx          <= 8'd0;
            cy          <= 7'd0;
            flush       <= 1'b0;
            dir_left    <= 1'b0;
            old_x       <= 8'd0;
            xpos_q      <= X_START8;
            addr_q      <= '0;
            ready_q     <= 1'b0;
            move_done_q <= 1'b0;
            pv_q        <= 1'b0;
            pdraw_q     <= 1'b0;
            px_q        <= 8'd0;
            py_q        <= 7'd0;
        end else begin
            pv_q        <= 1'b0;
            move_done_q <= 1'b0;
            if (in_sweep) begin
                if (!flush) begin
                    pv_q    <= 1'b1;
                    pdraw_q <= is_draw;
                    px_q    <= base_x + cx;
                    py_q    <= base_y + cy;
                    if (last_pix) begin
                        flush  <= 1'b1;
                        cx     <= 8'd0;
                        cy     <= 7'd0;
                        addr_q <= '0;
                    end else begin
                        if (cx == sw_m1) begin
                            cx <= 8'd0;
                            cy <= cy + 7'd1;
                        end else begin
                            cx <= cx + 8'd1;
                        end
                        if (is_draw)
                            addr_q <= addr_q + 1'b1;
                    end
                end else begin
                    // one drain cycle so the last pixel leaves before the state changes
                    flush <= 1'b0;
                    case (state)
                        S_CLEAR: state <= S_DRAW;
                        S_ERASE: state <= S_REDRAW;
                        S_DRAW: begin
                            state   <= S_READY;
                            ready_q <= 1'b1;
                        end
                        default: begin
                            state       <= S_READY;
                            ready_q     <= 1'b1;
                            move_done_q <= 1'b1;
                        end
                    endcase
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            state  <= S_CLEAR;
                            xpos_q <= X_START8;
                        end
                    end
                    S_READY: begin
                        if (left ^ right) begin
                            dir_left <= left;
                            state    <= S_UPDATE;
                            ready_q  <= 1'b0;
                        end
                    end
                    S_UPDATE: begin
                        old_x  <= xpos_q;
                        xpos_q <= target;
                        if (target != xpos_q) begin
                            state <= S_ERASE;
                        end else begin
                            state       <= S_READY;
                            ready_q     <= 1'b1;
                            move_done_q <= 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    // strobe and colour come straight from rom_data so transparency costs no extra cycle
    assign drawEn    = pv_q && (!pdraw_q || (rom_data != TRANSPARENT));
    assign colourOut = (pv_q && pdraw_q) ? rom_data : 3'b000;
    assign xout      = px_q;
    assign yout      = py_q;
    assign rom_addr  = addr_q;
    assign xpos      = xpos_q;
    assign ready     = ready_q;
    assign moveDone  = move_done_q;

endmodule

// File: tb/tb_sprite_mover.sv
// Scoreboard bench for sprite_mover: expected pixel writes and post-move xpos
// values are queued as stimulus is driven and popped as the DUT produces them.
module tb_sprite_mover;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       left;
    logic       right;
    logic [2:0] rom_data = 3'b000;
    logic [6:0] rom_addr;
    logic [7:0] xout;
    logic [6:0] yout;
    logic [2:0] colourOut;
    logic       drawEn;
    logic [7:0] xpos;
    logic       ready;
    logic       moveDone;

    sprite_mover dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .left      (left),
        .right     (right),
        .rom_data  (rom_data),
        .rom_addr  (rom_addr),
        .xout      (xout),
        .yout      (yout),
        .colourOut (colourOut),
        .drawEn    (drawEn),
        .xpos      (xpos),
        .ready     (ready),
        .moveDone  (moveDone)
    );

    always #5 clk = ~clk;

    logic [2:0] rom_mem [0:127];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    logic [17:0] exp_q[$];
    int          xq[$];
    int          wr_cnt = 0;
    int          md_cnt = 0;
    int          max_x  = 0;
    int          mx;
    logic [17:0] e;

    always @(negedge clk) begin
        if (drawEn) begin
            wr_cnt++;
            if (int'(xout) > max_x) max_x = int'(xout);
            chk("sb_avail", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("wr_x", int'(xout), int'(e[17:10]));
                chk("wr_y", int'(yout), int'(e[9:3]));
                chk("wr_col", int'(colourOut), int'(e[2:0]));
            end
        end
        if (moveDone) begin
            md_cnt++;
            chk("xq_avail", int'(xq.size() > 0), 1);
            if (xq.size() > 0)
                chk("xpos_after_move", int'(xpos), xq.pop_front());
        end
    end

    task automatic push_sweep(input int bx, input int by, input int w, input int h, input bit draw);
        logic [2:0] col;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < w; c++) begin
                col = draw ? rom_mem[r * 11 + c] : 3'b000;
                if (!draw || col != 3'b000)
                    exp_q.push_back({8'(bx + c), 7'(by + r), col});
            end
        end
    endtask

    task automatic model_move(input bit go_left);
        int t;
        if (go_left) t = (mx >= 5) ? mx - 5 : 0;
        else         t = (mx + 5 > 149) ? 149 : mx + 5;
        if (t != mx) begin
            push_sweep(mx, 105, 11, 10, 1'b0);
            push_sweep(t, 105, 11, 10, 1'b1);
        end
        xq.push_back(t);
        mx = t;
    endtask

    task automatic wait_settle(input int tgt, input int budget, input string tag);
        bit hit = 1'b0;
        for (int i = 0; i < budget && !hit; i++) begin
            @(negedge clk);
            if (ready && int'(xpos) == tgt) hit = 1'b1;
        end
        chk(tag, int'(hit), 1);
    endtask

    task automatic phase_end(input string tag);
        @(negedge clk);
        chk({tag, "_sb_empty"}, exp_q.size(), 0);
        chk({tag, "_xq_empty"}, xq.size(), 0);
        chk({tag, "_xpos"}, int'(xpos), mx);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_xout"}, int'(xout), 0);
        chk({tag, "_yout"}, int'(yout), 0);
        chk({tag, "_colour"}, int'(colourOut), 0);
        chk({tag, "_drawEn"}, int'(drawEn), 0);
        chk({tag, "_ready"}, int'(ready), 0);
        chk({tag, "_moveDone"}, int'(moveDone), 0);
        chk({tag, "_rom_addr"}, int'(rom_addr), 0);
        chk({tag, "_xpos"}, int'(xpos), 73);
    endtask

    task automatic do_start(input string tag);
        int w0, n;
        w0 = wr_cnt;
        push_sweep(0, 0, 160, 120, 1'b0);
        push_sweep(73, 105, 11, 10, 1'b1);
        n = exp_q.size();
        mx = 73;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_settle(73, 25000, {tag, "_ready"});
        chk({tag, "_writes"}, wr_cnt - w0, n);
        phase_end(tag);
    endtask

    initial begin
        int m0, w0, nmoves;
        bit hit;
        for (int i = 0; i < 128; i++) rom_mem[i] = 3'(i % 7);
        reset = 1'b1; start = 1'b0; left = 1'b0; right = 1'b0; mx = 73;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_ready", int'(ready), 0);

        // T1: clear + first draw
        do_start("t1");

        // T2: single left
        m0 = md_cnt;
        model_move(1'b1);
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        wait_settle(68, 500, "t2_settle");
        phase_end("t2");
        chk("t2_movedone", md_cnt - m0, 1);

        // T3: held left down to 0, then a no-op left
        m0 = md_cnt; nmoves = 0;
        while (mx != 0) begin model_move(1'b1); nmoves++; end
        left = 1'b1;
        wait_settle(0, 6000, "t3_settle");
        left = 1'b0;
        phase_end("t3");
        chk("t3_movedone", md_cnt - m0, nmoves);
        w0 = wr_cnt; m0 = md_cnt;
        model_move(1'b1);
        left = 1'b1;
        @(negedge clk);
        left = 1'b0;
        wait_settle(0, 50, "t3_noop_settle");
        phase_end("t3_noop");
        chk("t3_noop_writes", wr_cnt - w0, 0);
        chk("t3_noop_movedone", md_cnt - m0, 1);

        // T5: both commands high is ignored
        w0 = wr_cnt;
        left = 1'b1; right = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t5_ready", int'(ready), 1);
            chk("t5_drawEn", int'(drawEn), 0);
        end
        left = 1'b0; right = 1'b0;
        chk("t5_writes", wr_cnt - w0, 0);
        phase_end("t5");

        // T6: reset in the middle of an erase, then a fresh start
        model_move(1'b0);
        right = 1'b1;
        @(negedge clk);
        right = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50 && !hit; i++) begin
            @(negedge clk);
            if (drawEn) hit = 1'b1;
        end
        chk("t6_erase_seen", int'(hit), 1);
        repeat (20) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        exp_q.delete();
        xq.delete();
        mx = 73;
        check_reset_outputs("t6_rst");
        reset = 1'b0;
        w0 = wr_cnt;
        repeat (5) @(negedge clk);
        chk("t6_idle_writes", wr_cnt - w0, 0);
        chk("t6_idle_ready", int'(ready), 0);
        do_start("t6");

        // T4: held right until the clamp
        m0 = md_cnt; nmoves = 0;
        while (mx != 149) begin model_move(1'b0); nmoves++; end
        right = 1'b1;
        wait_settle(149, 6000, "t4_settle");
        right = 1'b0;
        phase_end("t4");
        chk("t4_movedone", md_cnt - m0, nmoves);
        w0 = wr_cnt;
        model_move(1'b0);
        right = 1'b1;
        @(negedge clk);
        right = 1'b0;
        wait_settle(149, 50, "t4_noop_settle");
        phase_end("t4_noop");
        chk("t4_noop_writes", wr_cnt - w0, 0);
        chk("max_x_on_screen", int'(max_x <= 159), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
